// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter controller for the RISC core. Holds the PC that addresses
//   the instruction memory and chooses the next PC on every retiring
//   instruction: PC+1, branch, JMP, ILLOP trap, fetch-fault trap or interrupt.
//   Also handles the reset vector, run/halt gating and imem stalls, and
//   produces the XP (R30) return-address write when a trap is taken.
//   The PC is a word address; bit 31 is the supervisor bit.
//
// Ports
//   clk         in   1   clock, all state changes on the rising edge
//   rst         in   1   synchronous reset, active-high
//   run         in   1   1 = execute, 0 = halt at the instruction boundary
//   imem_ready  in   1   instruction at pc is valid this cycle
//   pcsel       in   2   0 PC+1, 1 branch, 2 JMP, 3 ILLOP
//   branch_tgt  in   31  branch target (low 31 bits, word address)
//   jump_tgt    in   32  JMP target from the register file
//   irq         in   1   interrupt request (pulse or level)
//   pc          out  32  current PC to imem
//   pc_plus1    out  32  {pc[31], pc[30:0]+1}
//   commit      out  1   instruction at pc retires this cycle
//   supervisor  out  1   pc[31]
//   xp_we       out  1   one-cycle write strobe for XP on a trap
//   xp_data     out  32  trap return address (pc_plus1 of the trapped instruction)
//   trap_cause  out  2   0 none, 1 ILLOP, 2 fetch fault, 3 interrupt
//   dbg_state   out  2   FSM state: 0 HALT, 1 RUN, 2 STALL
//
// Handshake: commit is a valid-style strobe with no back-pressure. It is high
// in exactly the cycles where the FSM is not halted, run=1 and imem_ready=1;
// the PC, the pending-interrupt flag consumption and any xp_we pulse all
// happen on the rising edge that ends a commit cycle and at no other edge.

module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter logic [31:0] ILLOP_ADDR = 32'h8000_0001,
  parameter logic [31:0] XADR_ADDR  = 32'h8000_0002,
  parameter int          IMEM_AW    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        imem_ready,
  input  logic [1:0]  pcsel,
  input  logic [30:0] branch_tgt,
  input  logic [31:0] jump_tgt,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic        commit,
  output logic        supervisor,
  output logic        xp_we,
  output logic [31:0] xp_data,
  output logic [1:0]  trap_cause,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_ILLOP = 2'd1;
  localparam logic [1:0] CAUSE_FAULT = 2'd2;
  localparam logic [1:0] CAUSE_IRQ   = 2'd3;

  // First word address outside the instruction memory.
  localparam logic [30:0] IMEM_WORDS = 31'd1 << IMEM_AW;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        irq_pend_q, irq_pend_d;

  logic        fetch_fault;
  logic        irq_taken;
  logic        trap;
  logic [1:0]  cause;

  // Datapath and commit decode.
  always_comb begin
    pc_plus1    = {pc_q[31], pc_q[30:0] + 31'd1};
    fetch_fault = (pc_q[30:0] >= IMEM_WORDS);
    // Reset wins over everything, so no commit (and no xp_we) while rst is high.
    commit      = ~rst & (state_q != ST_HALT) & run & imem_ready;

    cause     = CAUSE_NONE;
    irq_taken = 1'b0;
    if (fetch_fault) begin
      cause = CAUSE_FAULT;
    end else if (pcsel == 2'd3) begin
      cause = CAUSE_ILLOP;
    end else if (irq_pend_q & ~pc_q[31]) begin
      // Interrupts are only taken from user mode.
      cause     = CAUSE_IRQ;
      irq_taken = commit;
    end
    trap = commit & (cause != CAUSE_NONE);
  end

  // Next PC, next FSM state and pending-interrupt tracking.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;

    if (commit) begin
      if (trap) begin
        pc_d = (cause == CAUSE_IRQ) ? XADR_ADDR : ILLOP_ADDR;
      end else begin
        case (pcsel)
          2'd0:    pc_d = pc_plus1;
          2'd1:    pc_d = {pc_q[31], branch_tgt};
          // JMP can drop supervisor mode but never gain it.
          2'd2:    pc_d = {pc_q[31] & jump_tgt[31], jump_tgt[30:0]};
          default: pc_d = pc_q;
        endcase
      end
    end

    case (state_q)
      ST_HALT: begin
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run)             state_d = ST_HALT;
        else if (!imem_ready) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (!run)            state_d = ST_HALT;
        else if (imem_ready) state_d = ST_RUN;
      end
      default: state_d = ST_HALT;
    endcase

    // A new request in the same cycle another is taken stays pending.
    irq_pend_d = irq | (irq_pend_q & ~irq_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HALT;
      pc_q       <= RESET_ADDR;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  always_comb begin
    pc         = pc_q;
    supervisor = pc_q[31];
    xp_we      = trap;
    xp_data    = pc_plus1;
    trap_cause = trap ? cause : CAUSE_NONE;
    dbg_state  = state_q;
  end

endmodule
